// File: rtl/core_op_arbiter.sv
// Round-robin issue arbiter for a shared core_op datapath: reserves the result slot
// of every accepted op so mixed-latency results never collide, and serialises the FMADD accumulator.
module core_op_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_BITS     = 2,
    parameter int OP_BITS     = 3,
    parameter int ADD_SUB_LAT = 1,
    parameter int MUL_LAT     = 1,
    parameter int DIV_LAT     = 3,
    parameter int FMA_LAT     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*OP_BITS-1:0] req_op_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       issue_valid_o,
    output logic [OP_BITS-1:0]         issue_op_o,
    output logic [ID_BITS-1:0]         issue_sel_o,
    output logic                       res_valid_o,
    output logic [ID_BITS-1:0]         res_id_o,
    output logic                       fma_locked_o,
    output logic [ID_BITS-1:0]         fma_owner_o
);

    localparam int MAX_AM  = (ADD_SUB_LAT > MUL_LAT) ? ADD_SUB_LAT : MUL_LAT;
    localparam int MAX_DF  = (DIV_LAT > FMA_LAT) ? DIV_LAT : FMA_LAT;
    localparam int MAX_LAT = (MAX_AM > MAX_DF) ? MAX_AM : MAX_DF;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(0);
    localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(1);
    localparam logic [OP_BITS-1:0] OP_MUL = OP_BITS'(2);
    localparam logic [OP_BITS-1:0] OP_DIV = OP_BITS'(3);
    localparam logic [OP_BITS-1:0] OP_FMA = OP_BITS'(4);

    function automatic logic [LAT_W-1:0] lat_of(input logic [OP_BITS-1:0] op);
        case (op)
            OP_ADD, OP_SUB: lat_of = LAT_W'(ADD_SUB_LAT);
            OP_MUL:         lat_of = LAT_W'(MUL_LAT);
            OP_DIV:         lat_of = LAT_W'(DIV_LAT);
            OP_FMA:         lat_of = LAT_W'(FMA_LAT);
            default:        lat_of = '0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [OP_BITS-1:0] op);
        op_legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
                   (op == OP_DIV) || (op == OP_FMA);
    endfunction

    logic [MAX_LAT:0]              pipe_vld_q, pipe_vld_d, shift_vld;
    logic [MAX_LAT:0][ID_BITS-1:0] pipe_id_q, pipe_id_d, shift_id;
    logic [ID_BITS-1:0]            rr_q, rr_d;
    logic                          fma_locked_q, fma_locked_d;
    logic [ID_BITS-1:0]            fma_owner_q, fma_owner_d;
    logic                          issue_valid_q, issue_valid_d;
    logic [OP_BITS-1:0]            issue_op_q, issue_op_d;
    logic [ID_BITS-1:0]            issue_sel_q, issue_sel_d;

    logic [OP_BITS-1:0]            op_k  [NUM_REQ];
    logic [LAT_W-1:0]              lat_k [NUM_REQ];
    logic [NUM_REQ-1:0]            is_fma;
    logic [NUM_REQ-1:0]            elig;
    logic                          grant_vld;
    logic [ID_BITS-1:0]            grant_id;

    // Eligibility is judged against the post-shift pipe, so a slot draining this edge is reusable.
    for (genvar gi = 0; gi <= MAX_LAT; gi++) begin : g_shift
        if (gi < MAX_LAT) begin : g_mid
            assign shift_vld[gi] = pipe_vld_q[gi+1];
            assign shift_id[gi]  = pipe_id_q[gi+1];
        end else begin : g_top
            assign shift_vld[gi] = 1'b0;
            assign shift_id[gi]  = '0;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign op_k[gi]   = req_op_i[gi*OP_BITS +: OP_BITS];
        assign lat_k[gi]  = lat_of(op_k[gi]);
        assign is_fma[gi] = (op_k[gi] == OP_FMA);
        assign elig[gi]   = req_valid_i[gi] && op_legal(op_k[gi]) && !shift_vld[lat_k[gi]] &&
                            (!is_fma[gi] || !fma_locked_q || (fma_owner_q == ID_BITS'(gi)));
    end

    always_comb begin : arb
        logic [ID_BITS-1:0] idx_id;
        int                 idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_id    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_id = ID_BITS'(idx);
            if (!grant_vld && elig[idx_id]) begin
                grant_vld = 1'b1;
                grant_id  = idx_id;
            end
        end
    end

    always_comb begin
        req_ready_o   = '0;
        rr_d          = rr_q;
        pipe_vld_d    = shift_vld;
        pipe_id_d     = shift_id;
        fma_locked_d  = fma_locked_q;
        fma_owner_d   = fma_owner_q;
        issue_valid_d = grant_vld;
        issue_op_d    = '0;
        issue_sel_d   = '0;
        if (grant_vld) begin
            req_ready_o = rst_i ? (NUM_REQ'(1) << grant_id) : '0;
            rr_d        = (grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            pipe_vld_d[lat_k[grant_id]] = 1'b1;
            pipe_id_d[lat_k[grant_id]]  = grant_id;
            issue_op_d  = op_k[grant_id];
            issue_sel_d = grant_id;
            if (is_fma[grant_id]) begin
                if (req_last_i[grant_id]) begin
                    fma_locked_d = 1'b0;
                end else begin
                    fma_locked_d = 1'b1;
                    fma_owner_d  = grant_id;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pipe_vld_q    <= '0;
            pipe_id_q     <= '0;
            rr_q          <= '0;
            fma_locked_q  <= 1'b0;
            fma_owner_q   <= '0;
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_sel_q   <= '0;
        end else begin
            pipe_vld_q    <= pipe_vld_d;
            pipe_id_q     <= pipe_id_d;
            rr_q          <= rr_d;
            fma_locked_q  <= fma_locked_d;
            fma_owner_q   <= fma_owner_d;
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_sel_q   <= issue_sel_d;
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_op_o    = issue_op_q;
    assign issue_sel_o   = issue_sel_q;
    assign res_valid_o   = pipe_vld_q[0];
    assign res_id_o      = pipe_id_q[0];
    assign fma_locked_o  = fma_locked_q;
    assign fma_owner_o   = fma_owner_q;

endmodule

// File: tb/tb_core_op_arbiter.sv
// Directed bench for core_op_arbiter: hand-derived grant sequence per step, scoreboard of
// expected issue/result cycles, and a tiny accumulator-lock model.
module tb_core_op_arbiter;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3, FMA = 3'd4;

    typedef struct {
        int         cyc;
        logic [2:0] op;
        logic [1:0] id;
    } ev_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [3:0]  req_valid_i = '0;
    logic [11:0] req_op_i = '0;
    logic [3:0]  req_last_i = '0;
    logic [3:0]  req_ready_o;
    logic        issue_valid_o;
    logic [2:0]  issue_op_o;
    logic [1:0]  issue_sel_o;
    logic        res_valid_o;
    logic [1:0]  res_id_o;
    logic        fma_locked_o;
    logic [1:0]  fma_owner_o;

    core_op_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .issue_valid_o(issue_valid_o), .issue_op_o(issue_op_o), .issue_sel_o(issue_sel_o),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o),
        .fma_locked_o(fma_locked_o), .fma_owner_o(fma_owner_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    ev_t  res_q[$];
    ev_t  iss_q[$];
    logic exp_locked = 1'b0;
    logic [1:0] exp_owner = 2'd0;

    function automatic int lat(input logic [2:0] op);
        case (op)
            DIV:     return 3;
            FMA:     return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string name);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk(32'(req_ready_o),   0, {tag, "_ready"});
        chk(32'(issue_valid_o), 0, {tag, "_issue_valid"});
        chk(32'(issue_op_o),    0, {tag, "_issue_op"});
        chk(32'(issue_sel_o),   0, {tag, "_issue_sel"});
        chk(32'(res_valid_o),   0, {tag, "_res_valid"});
        chk(32'(res_id_o),      0, {tag, "_res_id"});
        chk(32'(fma_locked_o),  0, {tag, "_locked"});
        chk(32'(fma_owner_o),   0, {tag, "_owner"});
    endtask

    task automatic check_outputs(input string tag);
        int  hit;
        ev_t e;
        hit = -1;
        for (int i = 0; i < res_q.size(); i++)
            if (hit < 0 && res_q[i].cyc == cyc) hit = i;
        chk(32'(res_valid_o), (hit >= 0) ? 1 : 0, {tag, "_res_valid"});
        if (hit >= 0) begin
            e = res_q[hit];
            res_q.delete(hit);
            chk(32'(res_id_o), 32'(e.id), {tag, "_res_id"});
            $display("[TB] cyc %0d result id=%0d", cyc, e.id);
        end
        hit = -1;
        for (int i = 0; i < iss_q.size(); i++)
            if (hit < 0 && iss_q[i].cyc == cyc) hit = i;
        chk(32'(issue_valid_o), (hit >= 0) ? 1 : 0, {tag, "_issue_valid"});
        if (hit >= 0) begin
            e = iss_q[hit];
            iss_q.delete(hit);
            chk(32'(issue_op_o),  32'(e.op), {tag, "_issue_op"});
            chk(32'(issue_sel_o), 32'(e.id), {tag, "_issue_sel"});
        end
        chk(32'(fma_locked_o), 32'(exp_locked), {tag, "_locked"});
        if (exp_locked) chk(32'(fma_owner_o), 32'(exp_owner), {tag, "_owner"});
    endtask

    // Inputs are already driven; check the combinational grant, then cross one edge.
    task automatic step(input logic [3:0] exp_rdy, input string tag);
        int         id;
        logic [2:0] op;
        #1;
        chk(32'(req_ready_o), 32'(exp_rdy), {tag, "_ready"});
        if (exp_rdy != 4'd0) begin
            id = 0;
            for (int i = 3; i >= 0; i--) if (exp_rdy[i]) id = i;
            op = req_op_i[id*3 +: 3];
            iss_q.push_back('{cyc + 1, op, 2'(id)});
            res_q.push_back('{cyc + 1 + lat(op), op, 2'(id)});
            if (op == FMA) begin
                if (req_last_i[id]) exp_locked = 1'b0;
                else begin
                    exp_locked = 1'b1;
                    exp_owner  = 2'(id);
                end
            end
            $display("[TB] cyc %0d %s accept id=%0d op=%0d", cyc, tag, id, op);
        end
        @(posedge clk_i);
        cyc++;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #12;
        check_zero("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Round-robin, all MUL
        req_valid_i = 4'b1111;
        req_op_i    = {MUL, MUL, MUL, MUL};
        step(4'b0001, "rr0"); step(4'b0010, "rr1"); step(4'b0100, "rr2");
        step(4'b1000, "rr3"); step(4'b0001, "rr4"); step(4'b0010, "rr5");
        req_valid_i = '0;
        for (int i = 0; i < 3; i++) step(4'b0000, "rr_idle");

        // DIV then ADD the next cycle: slot free, both accepted
        req_valid_i = 4'b0001; req_op_i = {ADD, ADD, ADD, DIV};
        step(4'b0001, "col_div");
        req_valid_i = 4'b0010;
        step(4'b0010, "col_add1");
        req_valid_i = '0;
        for (int i = 0; i < 4; i++) step(4'b0000, "col_idle");

        // DIV then ADD two cycles later: ADD's slot is taken, accepted one cycle after
        req_valid_i = 4'b0001;
        step(4'b0001, "stall_div");
        req_valid_i = '0;
        step(4'b0000, "stall_gap");
        req_valid_i = 4'b0010;
        step(4'b0000, "stall_block");
        step(4'b0010, "stall_add");
        req_valid_i = '0;
        for (int i = 0; i < 4; i++) step(4'b0000, "stall_idle");

        // Accumulator lock held by requester 2, requester 1 waits, requester 3 SUB passes
        req_valid_i = 4'b0110; req_op_i = {SUB, FMA, FMA, ADD}; req_last_i = 4'b0000;
        step(4'b0100, "fma_a");
        step(4'b0100, "fma_b");
        req_valid_i = 4'b1010;
        step(4'b0000, "fma_sub_slot");
        step(4'b1000, "fma_sub");
        req_valid_i = 4'b0110; req_last_i = 4'b0100;
        step(4'b0100, "fma_last");
        req_valid_i = 4'b0010; req_last_i = 4'b0000;
        step(4'b0010, "fma_r1");
        req_last_i = 4'b0010;
        step(4'b0010, "fma_r1_last");
        req_valid_i = '0; req_last_i = '0;
        for (int i = 0; i < 4; i++) step(4'b0000, "fma_idle");

        // Illegal ops from requester 0
        req_valid_i = 4'b0011; req_op_i = {ADD, ADD, ADD, 3'd5};
        step(4'b0010, "ill_5");
        req_valid_i = 4'b0001; req_op_i = {ADD, ADD, ADD, 3'd7};
        step(4'b0000, "ill_7a");
        step(4'b0000, "ill_7b");
        req_valid_i = 4'b0101; req_op_i = {ADD, MUL, ADD, 3'd6};
        step(4'b0100, "ill_6");
        req_valid_i = '0;
        for (int i = 0; i < 3; i++) step(4'b0000, "ill_idle");

        // Reset with three DIVs in flight
        req_valid_i = 4'b1111; req_op_i = {DIV, DIV, DIV, DIV};
        step(4'b1000, "rst_d3"); step(4'b0001, "rst_d0"); step(4'b0010, "rst_d1");
        rst_i = 1'b0;
        #1;
        check_zero("rst_async");
        res_q.delete();
        iss_q.delete();
        exp_locked = 1'b0;
        exp_owner  = 2'd0;
        step(4'b0000, "rst_hold0");
        step(4'b0000, "rst_hold1");
        rst_i = 1'b1;
        step(4'b0001, "rst_first");
        req_valid_i = '0;
        for (int i = 0; i < 5; i++) step(4'b0000, "rst_idle");

        chk(32'(res_q.size()), 0, "sb_res_empty");
        chk(32'(iss_q.size()), 0, "sb_iss_empty");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
